mem_arbiter: RTL and testbench

//  Shares the single-port 16K RAM (0x4000-0x7FFF) between the Z80 CPU and the video fetcher.
//  The ROM (0x0000-0x3FFF) is not arbitrated; ROM accesses complete with fixed timing.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_req_latch.sv | 38 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the Z80 / video RAM arbiter.
package mem_pkg;

  localparam int unsigned STARVE_W   = 4;
  localparam logic [1:0]  ROM_REGION = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    VACC,
    VACK,
    CACC,
    CACK
  } arb_state_t;

  typedef struct packed {
    logic        wr;
    logic [13:0] a;
    logic [7:0]  d;
  } cpu_req_t;

  function automatic logic is_rom(input logic [15:0] addr);
    return addr[15:14] == ROM_REGION;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU, video and memory-macro signals of the RAM/ROM arbiter.
interface mem_arbiter_if;

  logic        cpuStb;
  logic        cpuWr;
  logic [15:0] cpuA;
  logic [7:0]  cpuDi;
  logic [7:0]  cpuDo;
  logic        cpuAck;
  logic        cpuWait;
  logic        vidStb;
  logic [12:0] vmmAddr;
  logic [7:0]  vmmData;
  logic        vidAck;
  logic [13:0] romA;
  logic [7:0]  romDo;
  logic [13:0] ramA;
  logic        ramWr;
  logic [7:0]  ramDi;
  logic [7:0]  ramDo;
  logic        protoErr;

  modport slave (
    input  cpuStb, cpuWr, cpuA, cpuDi, vidStb, vmmAddr, romDo, ramDo,
    output cpuDo, cpuAck, cpuWait, vmmData, vidAck, romA, ramA, ramWr, ramDi, protoErr
  );

  modport master (
    output cpuStb, cpuWr, cpuA, cpuDi, vidStb, vmmAddr, romDo, ramDo,
    input  cpuDo, cpuAck, cpuWait, vmmData, vidAck, romA, ramA, ramWr, ramDi, protoErr
  );

endinterface

// File: rtl/mem_req_latch.sv
// Per-requester pending register: captures a strobed request, flags strobes that
// arrive while the requester is still outstanding (sticky err).
module mem_req_latch #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         stb,
  input  logic         take,
  input  logic         busy,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         pend,
  output logic [W-1:0] dout,
  output logic         err
);

  logic accept;

  // busy covers in-flight work that does not live in this register (ROM reads)
  assign accept = stb && !pend && !busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
      dout <= '0;
      err  <= 1'b0;
    end else begin
      if (clr) pend <= 1'b0;
      if (accept && take) begin
        pend <= 1'b1;
        dout <= din;
      end
      if (stb && !accept) err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the 16K single-port RAM between CPU and video; ROM reads bypass arbitration.
// MEM_ARB_CONTENTION_EN: video priority with MAXWAIT starvation limit; else fixed CPU priority.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MAXWAIT = 4
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  if (MAXWAIT < 1 || MAXWAIT > 15) begin : g_maxwait_range
    $error("mem_arbiter: MAXWAIT must be in 1..15");
  end

  cpu_req_t    cpu_in;
  cpu_req_t    cpu_q;
  logic        cpu_pend, cpu_err, cpu_clr;
  logic [12:0] vid_q;
  logic        vid_pend, vid_err, vid_clr;
  logic        rom_go, rom_busy, rom_ack, ram_rd_ack, cpu_ack, vid_ack, vid_win, ram_wr;
  logic [13:0] rom_a, ram_a;
  logic [7:0]  ram_di, cpu_do, cpu_do_q, vmm_q;
  arb_state_t  state;

  assign cpu_in  = '{wr: bus.cpuWr, a: bus.cpuA[13:0], d: bus.cpuDi};
  assign rom_go  = bus.cpuStb && !cpu_pend && !rom_busy && is_rom(bus.cpuA);
  assign cpu_clr = (state == CACC);
  assign vid_clr = (state == VACC);

  mem_req_latch #(.W($bits(cpu_req_t))) u_cpu_req (
    .clock (clock),
    .reset (reset),
    .stb   (bus.cpuStb),
    .take  (!is_rom(bus.cpuA)),
    .busy  (rom_busy),
    .clr   (cpu_clr),
    .din   (cpu_in),
    .pend  (cpu_pend),
    .dout  (cpu_q),
    .err   (cpu_err)
  );

  mem_req_latch #(.W(13)) u_vid_req (
    .clock (clock),
    .reset (reset),
    .stb   (bus.vidStb),
    .take  (1'b1),
    .busy  (1'b0),
    .clr   (vid_clr),
    .din   (bus.vmmAddr),
    .pend  (vid_pend),
    .dout  (vid_q),
    .err   (vid_err)
  );

`ifdef MEM_ARB_CONTENTION_EN
  localparam logic [STARVE_W-1:0] MAXW = STARVE_W'(MAXWAIT);
  logic [STARVE_W-1:0] starve;
  assign vid_win     = vid_pend && (!cpu_pend || starve < MAXW);
  assign bus.cpuWait = cpu_pend;
`else
  logic cpu_wait_q;
  assign vid_win     = vid_pend && !cpu_pend;
  assign bus.cpuWait = cpu_wait_q;
`endif

  // Memory data arrives in the ack cycle, so read data is steered straight through
  // while the ack is high and held in a register afterwards.
  assign cpu_do = rom_ack ? bus.romDo : (ram_rd_ack ? bus.ramDo : cpu_do_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rom_a      <= '0;
      rom_busy   <= 1'b0;
      rom_ack    <= 1'b0;
      ram_a      <= '0;
      ram_wr     <= 1'b0;
      ram_di     <= '0;
      ram_rd_ack <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_ack    <= 1'b0;
      cpu_do_q   <= '0;
      vmm_q      <= '0;
`ifdef MEM_ARB_CONTENTION_EN
      starve     <= '0;
`else
      cpu_wait_q <= 1'b0;
`endif
    end else begin
      rom_busy   <= rom_go;
      rom_ack    <= rom_busy;
      cpu_ack    <= rom_busy;
      ram_rd_ack <= 1'b0;
      vid_ack    <= 1'b0;
      if (rom_go) rom_a <= bus.cpuA[13:0];
      if (rom_ack || ram_rd_ack) cpu_do_q <= cpu_do;
      if (vid_ack) vmm_q <= bus.ramDo;

      case (state)
        IDLE: begin
          if (vid_win) begin
            state  <= VACC;
            ram_a  <= {1'b0, vid_q};
            ram_wr <= 1'b0;
          end else if (cpu_pend) begin
            state  <= CACC;
            ram_a  <= cpu_q.a;
            ram_wr <= cpu_q.wr;
            ram_di <= cpu_q.d;
`ifndef MEM_ARB_CONTENTION_EN
            cpu_wait_q <= 1'b1;
`endif
          end
        end
        VACC: begin
          vid_ack <= 1'b1;
          state   <= VACK;
        end
        VACK: begin
`ifdef MEM_ARB_CONTENTION_EN
          if (cpu_pend && starve != '1) starve <= starve + 1'b1;
`endif
          state <= IDLE;
        end
        CACC: begin
          ram_wr     <= 1'b0;
          cpu_ack    <= 1'b1;
          ram_rd_ack <= !ram_wr;
          state      <= CACK;
        end
        CACK: begin
`ifdef MEM_ARB_CONTENTION_EN
          starve <= '0;
`else
          cpu_wait_q <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpuDo    = cpu_do;
  assign bus.cpuAck   = cpu_ack;
  assign bus.vmmData  = vid_ack ? bus.ramDo : vmm_q;
  assign bus.vidAck   = vid_ack;
  assign bus.romA     = rom_a;
  assign bus.ramA     = ram_a;
  assign bus.ramWr    = ram_wr;
  assign bus.ramDi    = ram_di;
  assign bus.protoErr = cpu_err | vid_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with synchronous RAM/ROM models.
module tb_mem_arbiter;

`ifdef MEM_ARB_CONTENTION_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  mem_arbiter_if bus();

  mem_arbiter #(.MAXWAIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  bit [7:0] ram_mem [16384];
  bit       ram_wv  [16384];

  // Unwritten RAM returns a fixed pattern; 0x4010 is preset to 0xA5.
  function automatic logic [7:0] ram_pat(input logic [13:0] a);
    return (a == 14'h0010) ? 8'hA5 : (a[7:0] ^ 8'h5C);
  endfunction

  always @(posedge clock) begin
    if (bus.ramWr) begin
      ram_mem[bus.ramA] <= bus.ramDi;
      ram_wv[bus.ramA]  <= 1'b1;
    end
    bus.ramDo <= ram_wv[bus.ramA] ? ram_mem[bus.ramA] : ram_pat(bus.ramA);
    bus.romDo <= bus.romA[7:0] ^ 8'hC3;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt, ack_cnt, cpu_at, vid_at, n_cpu, vid_before, vid_between, drain_vid;
  logic [7:0] cpu_val, vid_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.cpuStb  = 1'b0;
    bus.cpuWr   = 1'b0;
    bus.cpuA    = '0;
    bus.cpuDi   = '0;
    bus.vidStb  = 1'b0;
    bus.vmmAddr = '0;
    #1 reset = 1'b1;
    #2;
    check("rst_addr", 32'({bus.romA, bus.ramA}), 0);
    check("rst_data", 32'({bus.cpuDo, bus.vmmData, bus.ramDi}), 0);
    check("rst_flags", 32'({bus.cpuAck, bus.cpuWait, bus.vidAck, bus.ramWr, bus.protoErr}), 0);
    tick;
    reset = 1'b0;
    tick;
    tick;

    // 1: CPU RAM read 0x4010, idle video
    bus.cpuStb = 1'b1; bus.cpuWr = 1'b0; bus.cpuA = 16'h4010;
    tick; bus.cpuStb = 1'b0;
    check("t1_wait_t1", 32'(bus.cpuWait), CONT ? 1 : 0);
    check("t1_noack_t1", 32'(bus.cpuAck), 0);
    tick;
    check("t1_wait_t2", 32'(bus.cpuWait), 1);
    check("t1_ramA", 32'(bus.ramA), 32'h0010);
    tick;
    check("t1_ack_t3", 32'(bus.cpuAck), 1);
    check("t1_do", 32'(bus.cpuDo), 32'hA5);
    check("t1_wait_t3", 32'(bus.cpuWait), CONT ? 0 : 1);
    tick;
    check("t1_ack_t4", 32'(bus.cpuAck), 0);
    check("t1_do_hold", 32'(bus.cpuDo), 32'hA5);
    check("t1_wait_t4", 32'(bus.cpuWait), 0);

    // 2: write 0x5000=0x3C, then read back
    bus.cpuStb = 1'b1; bus.cpuWr = 1'b1; bus.cpuA = 16'h5000; bus.cpuDi = 8'h3C;
    wr_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      tick;
      if (i == 1) bus.cpuStb = 1'b0;
      wr_cnt += int'(bus.ramWr);
      if (i == 2) check("t2_ramA_di", 32'({bus.ramA, bus.ramDi}), 32'h10003C);
      if (i == 3) begin
        check("t2_wack", 32'(bus.cpuAck), 1);
        check("t2_do_untouched", 32'(bus.cpuDo), 32'hA5);
      end
    end
    check("t2_wr_pulses", 32'(wr_cnt), 1);
    bus.cpuStb = 1'b1; bus.cpuWr = 1'b0; bus.cpuA = 16'h5000;
    tick; bus.cpuStb = 1'b0;
    tick;
    tick;
    check("t2_rack", 32'(bus.cpuAck), 1);
    check("t2_readback", 32'(bus.cpuDo), 32'h3C);

    // 3/7: simultaneous CPU RAM read and video fetch
    bus.cpuStb = 1'b1; bus.cpuWr = 1'b0; bus.cpuA = 16'h4020;
    bus.vidStb = 1'b1; bus.vmmAddr = 13'h0123;
    cpu_at = 0; vid_at = 0; cpu_val = '0; vid_val = '0;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (i == 1) begin bus.cpuStb = 1'b0; bus.vidStb = 1'b0; end
      if (bus.cpuAck) begin cpu_at = i; cpu_val = bus.cpuDo; end
      if (bus.vidAck) begin vid_at = i; vid_val = bus.vmmData; end
    end
    check("t3_vid_ack_cycle", 32'(vid_at), CONT ? 3 : 6);
    check("t3_cpu_ack_cycle", 32'(cpu_at), CONT ? 6 : 3);
    check("t3_vmm_data", 32'(vid_val), 32'h7F);
    check("t3_cpu_data", 32'(cpu_val), 32'h7C);

    // 4: video streaming against a pending CPU read, twice
    bus.cpuStb = 1'b1; bus.cpuA = 16'h4030;
    bus.vidStb = 1'b1; bus.vmmAddr = 13'h0040;
    n_cpu = 0; vid_before = 0; vid_between = 0;
    for (int i = 1; i <= 60 && n_cpu < 2; i++) begin
      tick;
      bus.cpuStb = 1'b0;
      bus.vidStb = 1'b0;
      if (bus.vidAck) begin
        if (n_cpu == 0) vid_before++;
        else vid_between++;
        bus.vidStb = 1'b1;
      end
      if (bus.cpuAck) begin
        n_cpu++;
        if (n_cpu == 1) bus.cpuStb = 1'b1;
      end
    end
    bus.cpuStb = 1'b0;
    bus.vidStb = 1'b0;
    check("t4_cpu_acks_in_budget", 32'(n_cpu), 2);
    check("t4_vid_before_cpu", 32'(vid_before), CONT ? 4 : 0);
    check("t4_vid_after_reset_starve", 32'(vid_between), CONT ? 4 : 0);
    check("t4_no_proto_err", 32'(bus.protoErr), 0);
    drain_vid = 0;
    for (int i = 1; i <= 10; i++) begin
      tick;
      drain_vid += int'(bus.vidAck);
    end
    check("t4_drain_vid", 32'(drain_vid), 1);

    // 5: ROM read during video traffic
    bus.cpuStb = 1'b1; bus.cpuWr = 1'b0; bus.cpuA = 16'h0001;
    bus.vidStb = 1'b1; bus.vmmAddr = 13'h0050;
    tick; bus.cpuStb = 1'b0; bus.vidStb = 1'b0;
    check("t5_romA", 32'(bus.romA), 1);
    check("t5_wait_t1", 32'(bus.cpuWait), 0);
    tick;
    check("t5_ack_t2", 32'(bus.cpuAck), 1);
    check("t5_rom_data", 32'(bus.cpuDo), 32'hC2);
    check("t5_wait_t2", 32'(bus.cpuWait), 0);
    tick;
    check("t5_vid_ack", 32'(bus.vidAck), 1);
    check("t5_vmm_data", 32'(bus.vmmData), 32'h0C);
    check("t5_cpu_ack_t3", 32'(bus.cpuAck), 0);
    tick;

    // 6a: second strobe while pending
    bus.cpuStb = 1'b1; bus.cpuWr = 1'b0; bus.cpuA = 16'h4010;
    tick;
    tick; bus.cpuStb = 1'b0;
    check("t6_proto_err", 32'(bus.protoErr), 1);
    ack_cnt = 0;
    for (int i = 3; i <= 8; i++) begin
      tick;
      ack_cnt += int'(bus.cpuAck);
    end
    check("t6_single_ack", 32'(ack_cnt), 1);

    // 6b: reset while the CPU write is in CACC
    bus.cpuStb = 1'b1; bus.cpuWr = 1'b1; bus.cpuA = 16'h4100; bus.cpuDi = 8'h99;
    tick; bus.cpuStb = 1'b0;
    tick;
    check("t6_cacc_wr", 32'(bus.ramWr), 1);
    reset = 1'b1;
    #1;
    check("t6_rst_addr", 32'({bus.romA, bus.ramA}), 0);
    check("t6_rst_data", 32'({bus.cpuDo, bus.vmmData, bus.ramDi}), 0);
    check("t6_rst_flags", 32'({bus.cpuAck, bus.cpuWait, bus.vidAck, bus.ramWr, bus.protoErr}), 0);
    tick;
    reset = 1'b0;
    ack_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      tick;
      ack_cnt += int'(bus.cpuAck);
    end
    check("t6_no_ack_after_rst", 32'(ack_cnt), 0);
    bus.cpuStb = 1'b1; bus.cpuWr = 1'b0; bus.cpuA = 16'h4100;
    tick; bus.cpuStb = 1'b0;
    tick;
    tick;
    check("t6_abort_rack", 32'(bus.cpuAck), 1);
    check("t6_abort_no_write", 32'(bus.cpuDo), 32'h5C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
